// File: rtl/zacore_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zacore_mem_arbiter
// Brief    : Arbitrates a fetch port and a load/store port onto one memory
//            port, one transaction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module zacore_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RR_MODE    = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    // fetch channel
    input  logic                    i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]   i_fetch_addr,
    output logic                    o_fetch_ready,
    output logic                    o_fetch_valid,
    output logic [DATA_WIDTH-1:0]   o_fetch_data,
    // data channel
    input  logic                    i_data_req,
    input  logic                    i_data_we,
    input  logic [ADDR_WIDTH-1:0]   i_data_addr,
    input  logic [DATA_WIDTH-1:0]   i_data_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_data_mask,
    output logic                    o_data_ready,
    output logic                    o_data_valid,
    output logic [DATA_WIDTH-1:0]   o_data_rdata,
    // memory port
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_mask,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int MASK_W = DATA_WIDTH / 8;

    generate
        if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
            $error("zacore_mem_arbiter: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_data;   // 1 = data channel was granted last
    logic                  r_owner_data;  // 1 = current transaction belongs to data
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [MASK_W-1:0]     r_mask;
    logic [DATA_WIDTH-1:0] r_fetch_data;
    logic [DATA_WIDTH-1:0] r_data_rdata;
    logic                  w_grant_data;
    logic                  w_grant_fetch;
    logic                  w_capture;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie, data wins unless round-robin says fetch is due
                if (i_data_req && (!i_fetch_req || (RR_MODE == 0) || !r_last_data)) begin
                    w_grant_data = 1'b1;
                    w_state_nxt  = REQ;
                end else if (i_fetch_req) begin
                    w_grant_fetch = 1'b1;
                    w_state_nxt   = REQ;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    if (r_we) begin
                        w_state_nxt = RESP;
                    end else if (i_mem_rvalid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_data  <= 1'b0;
            r_owner_data <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_fetch_data <= '0;
            r_data_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_data) begin
                r_last_data  <= 1'b1;
                r_owner_data <= 1'b1;
                r_we         <= i_data_we;
                r_addr       <= i_data_addr;
                r_wdata      <= i_data_wdata;
                r_mask       <= i_data_we ? i_data_mask : '0;
            end else if (w_grant_fetch) begin
                r_last_data  <= 1'b0;
                r_owner_data <= 1'b0;
                r_we         <= 1'b0;
                r_addr       <= i_fetch_addr;
                r_wdata      <= '0;
                r_mask       <= '0;
            end
            if (w_capture) begin
                if (r_owner_data) begin
                    r_data_rdata <= i_mem_rdata;
                end else begin
                    r_fetch_data <= i_mem_rdata;
                end
            end
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held
    assign o_fetch_ready = w_grant_fetch & i_rst_n;
    assign o_data_ready  = w_grant_data & i_rst_n;
    assign o_fetch_valid = (r_state == RESP) && !r_owner_data;
    assign o_data_valid  = (r_state == RESP) && r_owner_data;
    assign o_fetch_data  = r_fetch_data;
    assign o_data_rdata  = r_data_rdata;
    assign o_mem_req     = (r_state == REQ);
    assign o_mem_we      = (r_state == REQ) && r_we;
    assign o_mem_addr    = r_addr;
    assign o_mem_wdata   = r_wdata;
    assign o_mem_mask    = (r_state == REQ) ? r_mask : '0;

endmodule
`default_nettype wire

// File: tb/tb_zacore_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_zacore_mem_arbiter
// Brief    : Directed bench; responses are checked against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zacore_mem_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_fetch_req;
    logic [31:0] i_fetch_addr;
    logic        o_fetch_ready, o_fetch_valid;
    logic [31:0] o_fetch_data;
    logic        i_data_req, i_data_we;
    logic [31:0] i_data_addr, i_data_wdata;
    logic [3:0]  i_data_mask;
    logic        o_data_ready, o_data_valid;
    logic [31:0] o_data_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    // Second instance with fixed data priority, driven by the same inputs
    logic        d0_fetch_ready, d0_fetch_valid, d0_data_ready, d0_data_valid;
    logic [31:0] d0_fetch_data, d0_data_rdata, d0_mem_addr, d0_mem_wdata;
    logic        d0_mem_req, d0_mem_we;
    logic [3:0]  d0_mem_mask;

    zacore_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RR_MODE(1)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
        .o_fetch_ready(o_fetch_ready), .o_fetch_valid(o_fetch_valid), .o_fetch_data(o_fetch_data),
        .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
        .i_data_wdata(i_data_wdata), .i_data_mask(i_data_mask),
        .o_data_ready(o_data_ready), .o_data_valid(o_data_valid), .o_data_rdata(o_data_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    zacore_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RR_MODE(0)) u_dut_prio (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
        .o_fetch_ready(d0_fetch_ready), .o_fetch_valid(d0_fetch_valid), .o_fetch_data(d0_fetch_data),
        .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
        .i_data_wdata(i_data_wdata), .i_data_mask(i_data_mask),
        .o_data_ready(d0_data_ready), .o_data_valid(d0_data_valid), .o_data_rdata(d0_data_rdata),
        .o_mem_req(d0_mem_req), .o_mem_we(d0_mem_we), .o_mem_addr(d0_mem_addr),
        .o_mem_wdata(d0_mem_wdata), .o_mem_mask(d0_mem_mask),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    typedef struct packed {
        logic        is_data;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_fetch  = 32'h0;
    logic [31:0] m_data   = 32'h0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] all_outs();
        return {o_fetch_ready, o_fetch_valid, o_fetch_data, o_data_ready, o_data_valid,
                o_data_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask};
    endfunction

    // Monitor: every valid pulse must match the oldest expected response
    always @(negedge i_clk) begin
        if (o_fetch_valid || o_data_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid fetch_valid=%0b data_valid=%0b required=none",
                         o_fetch_valid, o_data_valid);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_channel", {o_data_valid, o_fetch_valid}, mon_e.is_data ? 2'b10 : 2'b01);
                chk("resp_data", mon_e.is_data ? o_data_rdata : o_fetch_data, mon_e.data);
            end
        end
    end

    // Entered at the accept cycle's negedge; returns at the start of the IDLE cycle after RESP
    task automatic serve(input int gnt_dly, input int rv_dly, input logic we,
                         input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input logic [3:0] e_mask,
                         input logic e_is_data, input logic drop, input logic poke);
        @(posedge i_clk); #1;
        if (drop) begin
            i_fetch_req = 1'b0;
            i_data_req  = 1'b0;
        end
        for (int k = 0; k < gnt_dly; k++) begin
            @(negedge i_clk);
            chk("mem_req_fields",
                {o_mem_req, o_mem_we, o_mem_addr, (we ? o_mem_wdata : 32'h0), o_mem_mask, o_fetch_ready, o_data_ready},
                {1'b1, we, e_addr, (we ? e_wdata : 32'h0), e_mask, 2'b00});
            @(posedge i_clk); #1;
            if (poke && k == 0) begin
                i_fetch_req  = 1'b1;
                i_fetch_addr = 32'h0000_0999;
            end
            if (poke && k == 2) i_fetch_req = 1'b0;
        end
        i_mem_gnt = 1'b1;
        if (!we && rv_dly == 0) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rdata;
        end
        @(negedge i_clk);
        chk("mem_req_fields",
            {o_mem_req, o_mem_we, o_mem_addr, (we ? o_mem_wdata : 32'h0), o_mem_mask, o_fetch_ready, o_data_ready},
            {1'b1, we, e_addr, (we ? e_wdata : 32'h0), e_mask, 2'b00});
        @(posedge i_clk); #1;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        if (!we && rv_dly > 0) begin
            for (int k = 1; k < rv_dly; k++) begin
                @(negedge i_clk);
                chk("wait_quiet", {o_mem_req, o_fetch_valid, o_data_valid}, 3'b000);
                @(posedge i_clk); #1;
            end
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rdata;
            @(negedge i_clk);
            chk("wait_quiet", {o_mem_req, o_fetch_valid, o_data_valid}, 3'b000);
            @(posedge i_clk); #1;
            i_mem_rvalid = 1'b0;
        end
        @(negedge i_clk);
        chk("resp_latency", {o_data_valid, o_fetch_valid}, e_is_data ? 2'b10 : 2'b01);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        is_d;
        logic [31:0] rd;
        i_rst_n = 1'b0; i_fetch_req = 1'b0; i_fetch_addr = '0;
        i_data_req = 1'b0; i_data_we = 1'b0; i_data_addr = '0; i_data_wdata = '0; i_data_mask = '0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_outputs", all_outs(), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("idle_outputs", all_outs(), 0);

        // Both requesters held: round-robin alternates starting with data
        @(posedge i_clk); #1;
        i_fetch_req = 1'b1; i_fetch_addr = 32'h0000_0040;
        i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h0000_0080;
        i_data_wdata = 32'h0000_0055; i_data_mask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            is_d = (i % 2 == 0);
            rd   = 32'hA000_0000 + i;
            @(negedge i_clk);
            chk("rr_grant", {o_data_ready, o_fetch_ready}, is_d ? 2'b10 : 2'b01);
            chk("prio_grant", {d0_data_ready, d0_fetch_ready}, 2'b10);
            sb_q.push_back({is_d, rd});
            if (is_d) m_data = rd; else m_fetch = rd;
            serve(0, 0, 1'b0, rd, is_d ? 32'h0000_0080 : 32'h0000_0040, 32'h0, 4'h0, is_d, 1'b0, 1'b0);
        end
        i_fetch_req = 1'b0;
        i_data_req  = 1'b0;

        // Fetch read, rvalid two cycles after grant
        @(posedge i_clk); #1;
        i_fetch_req = 1'b1; i_fetch_addr = 32'h0000_0100;
        @(negedge i_clk);
        chk("fetch_accept", {o_fetch_ready, o_data_ready}, 2'b10);
        sb_q.push_back({1'b0, 32'hDEADBEEF});
        m_fetch = 32'hDEADBEEF;
        serve(0, 2, 1'b0, 32'hDEADBEEF, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Masked data write, grant after two cycles
        i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h0000_0200;
        i_data_wdata = 32'h1234_5678; i_data_mask = 4'b0101;
        @(negedge i_clk);
        chk("write_accept", {o_fetch_ready, o_data_ready}, 2'b01);
        sb_q.push_back({1'b1, m_data});
        serve(2, 0, 1'b1, 32'h0, 32'h0000_0200, 32'h1234_5678, 4'b0101, 1'b1, 1'b1, 1'b0);

        // Data read with grant withheld 5 cycles; fetch pokes and withdraws meanwhile
        i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h0000_0300; i_data_mask = 4'hF;
        @(negedge i_clk);
        chk("read_accept", {o_fetch_ready, o_data_ready}, 2'b01);
        sb_q.push_back({1'b1, 32'hCAFE_F00D});
        m_data = 32'hCAFE_F00D;
        serve(5, 1, 1'b0, 32'hCAFE_F00D, 32'h0000_0300, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);

        // Stray rvalid while idle must be ignored
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BAD_F00D;
        @(negedge i_clk);
        chk("idle_rvalid_ignored", {o_fetch_valid, o_data_valid, o_fetch_data, o_data_rdata}, {2'b00, m_fetch, m_data});
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0;
        @(negedge i_clk);
        chk("idle_rvalid_ignored", {o_fetch_valid, o_data_valid, o_fetch_data, o_data_rdata}, {2'b00, m_fetch, m_data});

        // Reset asserted while waiting for read data
        @(posedge i_clk); #1;
        i_fetch_req = 1'b1; i_fetch_addr = 32'h0000_0400;
        @(negedge i_clk);
        chk("abandon_accept", {o_fetch_ready, o_data_ready}, 2'b10);
        @(posedge i_clk); #1;
        i_fetch_req = 1'b0; i_mem_gnt = 1'b1;
        @(posedge i_clk); #1;
        i_mem_gnt = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("reset_async", all_outs(), 0);
        m_fetch = 32'h0;
        m_data  = 32'h0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h7777_7777;
        @(negedge i_clk);
        chk("late_rvalid", {o_fetch_valid, o_data_valid, o_fetch_data, o_data_rdata}, 0);
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0;
        @(negedge i_clk);
        chk("late_rvalid", {o_fetch_valid, o_data_valid, o_fetch_data, o_data_rdata}, 0);

        // Normal fetch after reset recovery
        @(posedge i_clk); #1;
        i_fetch_req = 1'b1; i_fetch_addr = 32'h0000_0500;
        @(negedge i_clk);
        chk("recover_accept", {o_fetch_ready, o_data_ready}, 2'b10);
        sb_q.push_back({1'b0, 32'h1357_9BDF});
        m_fetch = 32'h1357_9BDF;
        serve(1, 1, 1'b0, 32'h1357_9BDF, 32'h0000_0500, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge i_clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
